// File: rtl/parity_arbiter.sv
// Round-robin arbiter sharing one parity stage among four 7-bit requesters.
// The captured word plus parity is held for a single valid/ready consumer.
module parity_arbiter #(
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [27:0] req_data,
    output logic [3:0]  grant,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic [1:0]  out_src,
    input  logic        out_ready
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t      r_state;
    logic [1:0]  r_last;
    logic [1:0]  w_win;
    logic        w_found;
    logic [6:0]  w_word;
    logic        w_par;

    // Search starts one past the last winner and wraps through all four sources.
    always_comb begin
        w_win   = 2'd0;
        w_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!w_found && req[r_last + 2'(k + 1)]) begin
                w_win   = r_last + 2'(k + 1);
                w_found = 1'b1;
            end
        end
        w_word = req_data[w_win*7 +: 7];
        w_par  = (^w_word) ^ ODD_PARITY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= 2'd3;
            grant     <= 4'b0000;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_src   <= 2'd0;
        end else begin
            grant <= 4'b0000;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        out_data  <= {w_par, w_word};
                        out_src   <= w_win;
                        r_last    <= w_win;
                        grant     <= 4'b0001 << w_win;
                        out_valid <= 1'b1;
                        r_state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
